// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs: CPU-wide definitions used by the FPU decode and execute stages.
//   fpu_oper_t / FPUOper_t : decoded FPU operation class
//   fpu_state_t            : fpu_move_exec sequencing state
//   FPU_FCSR_ADDR          : control register number of the FCSR
//   FPU_FIR_ADDR           : control register number of the FIR
//   FPU_FIR_VALUE          : default FIR contents
//   FPU_FCSR_WMASK         : default writable FCSR bits (FS bit 24, bits 17:0)
// -----------------------------------------------------------------------------
package cpu_defs;

   typedef enum logic [2:0] {
      FPU_OP_NONE    = 3'd0,
      FPU_OP_MTC1    = 3'd1,
      FPU_OP_MFC1    = 3'd2,
      FPU_OP_CTC1    = 3'd3,
      FPU_OP_CFC1    = 3'd4,
      FPU_OP_LW      = 3'd5,
      FPU_OP_SW      = 3'd6,
      FPU_OP_INVALID = 3'd7
   } fpu_oper_t;

   typedef fpu_oper_t FPUOper_t;

   typedef enum logic {
      FPU_ST_IDLE      = 1'b0,
      FPU_ST_WAIT_LOAD = 1'b1
   } fpu_state_t;

   localparam logic [4:0]  FPU_FCSR_ADDR  = 5'd31;
   localparam logic [4:0]  FPU_FIR_ADDR   = 5'd0;
   localparam logic [31:0] FPU_FIR_VALUE  = 32'h0000_0000;
   localparam logic [31:0] FPU_FCSR_WMASK = 32'h0103_FFFF;

   // Masked FCSR update: only bits set in wmask take the new value.
   function automatic logic [31:0] fcsr_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] wmask);
      return (old_val & ~wmask) | (new_val & wmask);
   endfunction

endpackage

// File: rtl/fpu_regfile.sv
// -----------------------------------------------------------------------------
// fpu_regfile: 32 x 32-bit floating-point register file.
//   clk, rst      : clock, synchronous active-high reset (all entries to 0)
//   we/waddr/wdata: single write port, committed on the rising edge
//   raddr1/rdata1 : combinational read port 1
//   raddr2/rdata2 : combinational read port 2
// Reads return the contents before any write on the same edge.
// -----------------------------------------------------------------------------
module fpu_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   output logic [31:0] rdata1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata2
);

   logic [31:0] regs [32];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'h0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

endmodule

// File: rtl/fpu_move_exec.sv
// -----------------------------------------------------------------------------
// fpu_move_exec: execute-stage FPU move/load/store unit.
// Owns the FPR file and FCSR, executes MTC1/CTC1/LWC1 writes and returns
// MFC1/CFC1/SWC1 source values to the integer pipeline.
//   clk, rst                 : clock, synchronous active-high reset
//   op_valid/op_ready/op     : decoded op handshake
//   raddr1                   : FPR read address for SWC1 (ft)
//   raddr2                   : FPR/control read address for MFC1/CFC1 (fs)
//   we, waddr                : decoder write enable and destination
//   gpr_data                 : integer source operand for MTC1/CTC1
//   load_valid, load_data    : returning LWC1 memory data
//   flush                    : pipeline flush, cancels same-cycle op and
//                              any outstanding load
//   result_valid/result_data : registered MFC1/CFC1/SWC1 value
//   invalid_op               : one-cycle pulse after an INVALID op is accepted
//   fcsr                     : current FCSR
// -----------------------------------------------------------------------------
module fpu_move_exec
   import cpu_defs::*;
#(
   parameter logic [31:0] FIR_VALUE  = FPU_FIR_VALUE,
   parameter logic [31:0] FCSR_WMASK = FPU_FCSR_WMASK
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   output logic        op_ready,
   input  fpu_oper_t   op,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] gpr_data,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        flush,
   output logic        result_valid,
   output logic [31:0] result_data,
   output logic        invalid_op,
   output logic [31:0] fcsr
);

   fpu_state_t  state;
   fpu_state_t  state_next;
   logic [4:0]  load_dst;
   logic        accept;
   logic        load_commit;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic        result_load;
   logic [31:0] result_next;

   assign accept      = op_valid && op_ready && !flush;
   // A returning load only lands while waiting and when not flushed.
   assign load_commit = (state == FPU_ST_WAIT_LOAD) && load_valid && !flush;

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FPU_ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_next = state;
      case (state)
         FPU_ST_IDLE: begin
            // LWC1 with we=0 writes nothing, so it does not wait either.
            if (accept && op == FPU_OP_LW && we) begin
               state_next = FPU_ST_WAIT_LOAD;
            end
         end
         FPU_ST_WAIT_LOAD: begin
            if (flush || load_valid) begin
               state_next = FPU_ST_IDLE;
            end
         end
         default: state_next = FPU_ST_IDLE;
      endcase
   end

   // ---- FSM outputs ----
   always_comb begin
      op_ready = (state == FPU_ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_dst <= 5'd0;
      end else if (accept && op == FPU_OP_LW) begin
         load_dst <= waddr;
      end
   end

   // Write port: load data has the port to itself because no op is
   // accepted while waiting for it.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = waddr;
      rf_wdata = gpr_data;
      if (load_commit) begin
         rf_we    = 1'b1;
         rf_waddr = load_dst;
         rf_wdata = load_data;
      end else if (accept && op == FPU_OP_MTC1 && we) begin
         rf_we = 1'b1;
      end
   end

   fpu_regfile u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fcsr <= 32'h0;
      end else if (accept && op == FPU_OP_CTC1 && we && waddr == FPU_FCSR_ADDR) begin
         fcsr <= fcsr_merge(fcsr, gpr_data, FCSR_WMASK);
      end
   end

   // Result source selection for the read-type ops.
   always_comb begin
      result_load = 1'b0;
      result_next = 32'h0;
      case (op)
         FPU_OP_MFC1: begin
            result_load = 1'b1;
            result_next = rdata2;
         end
         FPU_OP_CFC1: begin
            result_load = 1'b1;
            if (raddr2 == FPU_FCSR_ADDR) begin
               result_next = fcsr;
            end else if (raddr2 == FPU_FIR_ADDR) begin
               result_next = FIR_VALUE;
            end else begin
               result_next = 32'h0;
            end
         end
         FPU_OP_SW: begin
            result_load = 1'b1;
            result_next = rdata1;
         end
         default: begin
            result_load = 1'b0;
            result_next = 32'h0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_valid <= 1'b0;
         result_data  <= 32'h0;
         invalid_op   <= 1'b0;
      end else begin
         result_valid <= accept && result_load;
         invalid_op   <= accept && (op == FPU_OP_INVALID);
         if (accept && result_load) begin
            result_data <= result_next;
         end
      end
   end

endmodule

// File: tb/tb_fpu_move_exec.sv
// -----------------------------------------------------------------------------
// tb_fpu_move_exec: directed bench for fpu_move_exec with a behavioural model
// and per-cycle output comparison, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_fpu_move_exec;
   import cpu_defs::*;

   localparam logic [31:0] TB_FIR = 32'h0001_0A00;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic        op_ready;
   fpu_oper_t   op;
   logic [4:0]  raddr1, raddr2, waddr;
   logic        we;
   logic [31:0] gpr_data;
   logic        load_valid;
   logic [31:0] load_data;
   logic        flush;
   logic        result_valid;
   logic [31:0] result_data;
   logic        invalid_op;
   logic [31:0] fcsr;

   int checks = 0;
   int errors = 0;

   fpu_move_exec #(.FIR_VALUE(TB_FIR), .FCSR_WMASK(32'h0103_FFFF)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
      .raddr1(raddr1), .raddr2(raddr2), .we(we), .waddr(waddr),
      .gpr_data(gpr_data), .load_valid(load_valid), .load_data(load_data),
      .flush(flush), .result_valid(result_valid), .result_data(result_data),
      .invalid_op(invalid_op), .fcsr(fcsr)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_fpr [32];
   logic [31:0] m_fcsr;
   bit          m_busy;
   logic [4:0]  m_dst;
   logic        m_rv, m_inv;
   logic [31:0] m_rd;
   bit          chk_en = 0;

   always @(posedge clk) begin
      if (rst) begin
         foreach (m_fpr[i]) m_fpr[i] = 32'h0;
         m_fcsr = 0; m_busy = 0; m_dst = 0;
         m_rv = 0; m_inv = 0; m_rd = 0;
      end else begin
         m_rv = 0; m_inv = 0;
         if (m_busy) begin
            if (!flush && load_valid) m_fpr[m_dst] = load_data;
            if (flush || load_valid) m_busy = 0;
         end else if (op_valid && !flush) begin
            if (op == FPU_OP_MTC1 && we) m_fpr[waddr] = gpr_data;
            if (op == FPU_OP_CTC1 && we && waddr == 31)
               m_fcsr = (m_fcsr & 32'hFEFC_0000) | (gpr_data & 32'h0103_FFFF);
            if (op == FPU_OP_LW && we) begin m_busy = 1; m_dst = waddr; end
            if (op == FPU_OP_MFC1) begin m_rv = 1; m_rd = m_fpr[raddr2]; end
            if (op == FPU_OP_SW)   begin m_rv = 1; m_rd = m_fpr[raddr1]; end
            if (op == FPU_OP_CFC1) begin
               m_rv = 1;
               m_rd = (raddr2 == 31) ? m_fcsr : (raddr2 == 0) ? TB_FIR : 32'h0;
            end
            if (op == FPU_OP_INVALID) m_inv = 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_ready",  {31'b0, op_ready},     {31'b0, !m_busy});
         chk("m_rvalid", {31'b0, result_valid}, {31'b0, m_rv});
         chk("m_rdata",  result_data,           m_rd);
         chk("m_inv",    {31'b0, invalid_op},   {31'b0, m_inv});
         chk("m_fcsr",   fcsr,                  m_fcsr);
      end
   end

   task automatic idle_inputs();
      op_valid = 0; op = FPU_OP_NONE; raddr1 = 0; raddr2 = 0; we = 0;
      waddr = 0; gpr_data = 0; load_valid = 0; load_data = 0; flush = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op for one cycle; returns 1 time unit after the edge.
   task automatic issue(input fpu_oper_t o, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] wa, input logic [31:0] gd, input logic fl,
                        input logic w);
      op_valid = 1; op = o; raddr1 = r1; raddr2 = r2; waddr = wa;
      gpr_data = gd; flush = fl; we = w;
      tick();
      idle_inputs();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst = 1;
      tick(); tick();
      rst = 0;
      chk_en = 1;
      chk("rst_rvalid", {31'b0, result_valid}, 32'h0);
      chk("rst_rdata",  result_data, 32'h0);
      chk("rst_ready",  {31'b0, op_ready}, 32'h1);
      chk("rst_fcsr",   fcsr, 32'h0);

      issue(FPU_OP_MFC1, 0, 5, 0, 0, 0, 0);
      chk("mfc1_rst_valid", {31'b0, result_valid}, 32'h1);
      chk("mfc1_rst_data",  result_data, 32'h0);

      // MTC1 then MFC1 back to back
      issue(FPU_OP_MTC1, 0, 0, 3, 32'hDEAD_BEEF, 0, 1);
      chk("b2b_ready", {31'b0, op_ready}, 32'h1);
      issue(FPU_OP_MFC1, 0, 3, 0, 0, 0, 0);
      chk("mfc1_f3", result_data, 32'hDEAD_BEEF);
      chk("mfc1_f3_valid", {31'b0, result_valid}, 32'h1);

      // FCSR
      issue(FPU_OP_CTC1, 0, 0, 31, 32'hFFFF_FFFF, 0, 1);
      chk("fcsr_masked", fcsr, 32'h0103_FFFF);
      issue(FPU_OP_CFC1, 0, 31, 0, 0, 0, 0);
      chk("cfc1_31", result_data, 32'h0103_FFFF);
      issue(FPU_OP_CFC1, 0, 0, 0, 0, 0, 0);
      chk("cfc1_fir", result_data, TB_FIR);
      issue(FPU_OP_CFC1, 0, 25, 0, 0, 0, 0);
      chk("cfc1_25", result_data, 32'h0);
      issue(FPU_OP_CTC1, 0, 0, 5, 32'h0, 0, 1);
      chk("ctc1_other", fcsr, 32'h0103_FFFF);

      // LWC1 with a 3-cycle wait
      issue(FPU_OP_LW, 0, 0, 7, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         chk("lw_wait_ready", {31'b0, op_ready}, 32'h0);
         tick();
      end
      chk("lw_wait_ready", {31'b0, op_ready}, 32'h0);
      load_valid = 1; load_data = 32'h3F80_0000;
      tick();
      idle_inputs();
      chk("lw_done_ready", {31'b0, op_ready}, 32'h1);
      issue(FPU_OP_SW, 7, 0, 0, 0, 0, 0);
      chk("swc1_f7", result_data, 32'h3F80_0000);

      // Flush during WAIT_LOAD, then a stray load_valid in IDLE
      issue(FPU_OP_MTC1, 0, 0, 7, 32'h0000_1234, 0, 1);
      issue(FPU_OP_LW, 0, 0, 7, 0, 0, 1);
      tick();
      flush = 1;
      tick();
      idle_inputs();
      chk("flush_ready", {31'b0, op_ready}, 32'h1);
      load_valid = 1; load_data = 32'hFFFF_FFFF;
      tick();
      idle_inputs();
      issue(FPU_OP_MFC1, 0, 7, 0, 0, 0, 0);
      chk("flush_keep_f7", result_data, 32'h0000_1234);

      // Flush and load_valid together
      issue(FPU_OP_LW, 0, 0, 7, 0, 0, 1);
      flush = 1; load_valid = 1; load_data = 32'h5555_5555;
      tick();
      idle_inputs();
      chk("flush_lv_ready", {31'b0, op_ready}, 32'h1);
      issue(FPU_OP_MFC1, 0, 7, 0, 0, 0, 0);
      chk("flush_lv_f7", result_data, 32'h0000_1234);

      // INVALID pulse
      issue(FPU_OP_INVALID, 0, 0, 0, 0, 0, 0);
      chk("inv_pulse", {31'b0, invalid_op}, 32'h1);
      chk("inv_no_rv", {31'b0, result_valid}, 32'h0);
      tick();
      chk("inv_clear", {31'b0, invalid_op}, 32'h0);

      // MTC1 cancelled by flush, MTC1 with we=0
      issue(FPU_OP_MTC1, 0, 0, 4, 32'h0000_AAAA, 1, 1);
      issue(FPU_OP_MTC1, 0, 0, 5, 32'h0000_BBBB, 0, 0);
      issue(FPU_OP_MFC1, 0, 4, 0, 0, 0, 0);
      chk("flush_mtc1", result_data, 32'h0);
      issue(FPU_OP_MFC1, 0, 5, 0, 0, 0, 0);
      chk("we0_mtc1", result_data, 32'h0);
      tick();
      chk("rd_hold", result_data, 32'h0);
      chk("rv_drop", {31'b0, result_valid}, 32'h0);

      // Reset while waiting for a load
      issue(FPU_OP_LW, 0, 0, 9, 0, 0, 1);
      rst = 1; load_valid = 1; load_data = 32'h7777_7777;
      tick();
      rst = 0;
      idle_inputs();
      chk("rst_wait_ready", {31'b0, op_ready}, 32'h1);
      issue(FPU_OP_MFC1, 0, 9, 0, 0, 0, 0);
      chk("rst_wait_f9", result_data, 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
